// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg
//   Shared widths and helpers for the register-file write-port arbiter.
//   The widths come from the project-wide LEN_* macros. Each macro gets a
//   default here only when no shared include has defined it already.
//   Contents:
//     LEN_WORD, LEN_PREG_ADDR, LEN_CONTEXT  data / physical-reg / context widths
//     ENTRY_W                               width of one packed {pa_rd, d, ctx} entry
//     is_killed()                           squash predicate for a context tag
//     entry_pack() / get_pa() / get_d() / get_ctx()  entry pack and unpack

`ifndef LEN_WORD
`define LEN_WORD 32
`endif
`ifndef LEN_PREG_ADDR
`define LEN_PREG_ADDR 6
`endif
`ifndef LEN_CONTEXT
`define LEN_CONTEXT 4
`endif

package wb_arbiter_pkg;

  localparam int LEN_WORD      = `LEN_WORD;
  localparam int LEN_PREG_ADDR = `LEN_PREG_ADDR;
  localparam int LEN_CONTEXT   = `LEN_CONTEXT;
  localparam int ENTRY_W       = LEN_PREG_ADDR + LEN_WORD + LEN_CONTEXT;

  // A context is squashed when the hazard strobe is up and any of its tag
  // bits overlaps the set of contexts being squashed.
  function automatic logic is_killed(input logic                   hazard,
                                     input logic [LEN_CONTEXT-1:0] hazard_ctx,
                                     input logic [LEN_CONTEXT-1:0] ctx);
    return hazard & (|(ctx & hazard_ctx));
  endfunction

  // Entry layout, MSB to LSB: {pa_rd, d, ctx}.
  function automatic logic [ENTRY_W-1:0] entry_pack(input logic [LEN_PREG_ADDR-1:0] pa,
                                                    input logic [LEN_WORD-1:0]      d,
                                                    input logic [LEN_CONTEXT-1:0]   ctx);
    return {pa, d, ctx};
  endfunction

  function automatic logic [LEN_PREG_ADDR-1:0] get_pa(input logic [ENTRY_W-1:0] e);
    return e[ENTRY_W-1 -: LEN_PREG_ADDR];
  endfunction

  function automatic logic [LEN_WORD-1:0] get_d(input logic [ENTRY_W-1:0] e);
    return e[LEN_CONTEXT +: LEN_WORD];
  endfunction

  function automatic logic [LEN_CONTEXT-1:0] get_ctx(input logic [ENTRY_W-1:0] e);
    return e[LEN_CONTEXT-1:0];
  endfunction

endpackage

// File: rtl/wb_arbiter_queue.sv
// wb_queue
//   Per-requester write-back FIFO. Each entry has its own valid bit, so a
//   squash can invalidate entries in place. The holes this leaves stay in the
//   queue and are popped from the head on their own, without a grant.
//   Ports:
//     clk, rstn          clock, async active-low reset
//     push, push_entry   write one packed entry at wr_ptr (filtered upstream)
//     pop_grant          arbiter granted the current (valid) head
//     branch_hazard,
//     hazard_context     squash strobe and the contexts being squashed
//     full               all DEPTH slots occupied (holes included)
//     head_valid,
//     head_entry         head slot holds a valid entry, and its contents
//     entry_live         per slot: valid and not squashed this cycle
//     entry_pa           per slot pa_rd, slot j at [j*LEN_PREG_ADDR +: LEN_PREG_ADDR]

module wb_queue
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             push,
  input  logic [ENTRY_W-1:0]               push_entry,
  input  logic                             pop_grant,
  input  logic                             branch_hazard,
  input  logic [LEN_CONTEXT-1:0]           hazard_context,
  output logic                             full,
  output logic                             head_valid,
  output logic [ENTRY_W-1:0]               head_entry,
  output logic [DEPTH-1:0]                 entry_live,
  output logic [DEPTH*LEN_PREG_ADDR-1:0]   entry_pa
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pop;

  // An occupied head leaves either because it was granted or because it is
  // a hole left by an earlier squash.
  always_comb begin
    valid_d  = valid_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    pop      = (count_q != '0) && (!valid_q[rd_ptr_q] || pop_grant);

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && is_killed(branch_hazard, hazard_context, get_ctx(mem_q[i]))) begin
        valid_d[i] = 1'b0;
      end
    end

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end

    // A push never lands on the head slot being popped: push is only
    // accepted when the queue is not full.
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      mem_d[wr_ptr_q]   = push_entry;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Queue state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign full       = (count_q == CNT_W'(DEPTH));
  assign head_valid = valid_q[rd_ptr_q];
  assign head_entry = mem_q[rd_ptr_q];

  // View of the queue contents for the pending-write mask.
  always_comb begin
    entry_live = '0;
    entry_pa   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      entry_live[j] = valid_q[j] & ~is_killed(branch_hazard, hazard_context, get_ctx(mem_q[j]));
      entry_pa[j*LEN_PREG_ADDR +: LEN_PREG_ADDR] = get_pa(mem_q[j]);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Shares the single register-file write port among N_REQ execution units.
//   Each unit pushes results into its own wb_queue. A round-robin scheduler
//   drains one head per cycle into a registered write stage. Entries whose
//   context is squashed are discarded at every stage.
//   Ports:
//     clk, rstn                     clock, async active-low reset
//     req_order / req_accepted      per-unit write request / combinational accept
//     req_pa_rd, req_d_rd,
//     req_context                   packed per-unit address, data and context (unit i at [i*W +: W])
//     branch_hazard, hazard_context squash strobe and the contexts being squashed
//     w1_order, w1_pa_rd, w1_d_rd   write port towards reg_manage
//     pending_rd                    one bit per physical register with a live write in flight

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N_REQ-1:0]              req_order,
  output logic [N_REQ-1:0]              req_accepted,
  input  logic [N_REQ*LEN_PREG_ADDR-1:0] req_pa_rd,
  input  logic [N_REQ*LEN_WORD-1:0]     req_d_rd,
  input  logic [N_REQ*LEN_CONTEXT-1:0]  req_context,
  input  logic                          branch_hazard,
  input  logic [LEN_CONTEXT-1:0]        hazard_context,
  output logic                          w1_order,
  output logic [LEN_PREG_ADDR-1:0]      w1_pa_rd,
  output logic [LEN_WORD-1:0]           w1_d_rd,
  output logic [2**LEN_PREG_ADDR-1:0]   pending_rd
);

  localparam int RR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NUM_PREG = 2**LEN_PREG_ADDR;

  logic [N_REQ-1:0]               full;
  logic [N_REQ-1:0]               head_valid;
  logic [N_REQ-1:0]               push;
  logic [N_REQ-1:0]               candidate;
  logic [N_REQ-1:0]               pop_grant;
  logic [ENTRY_W-1:0]             head_entry [N_REQ];
  logic [DEPTH-1:0]               entry_live [N_REQ];
  logic [DEPTH*LEN_PREG_ADDR-1:0] entry_pa   [N_REQ];

  logic                           grant_found;
  logic [RR_W-1:0]                grant_idx;

  logic [RR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic                           stage_valid_q, stage_valid_d;
  logic [ENTRY_W-1:0]             stage_entry_q, stage_entry_d;
  logic                           stage_live;

  // Accept purely on free space. A full queue does not accept even when its
  // head leaves in the same cycle, which keeps the accept path short.
  always_comb begin
    req_accepted = '0;
    if (rstn) begin
      req_accepted = req_order & ~full;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      logic [LEN_PREG_ADDR-1:0] pa_in;
      logic [LEN_WORD-1:0]      d_in;
      logic [LEN_CONTEXT-1:0]   ctx_in;

      assign pa_in  = req_pa_rd[gi*LEN_PREG_ADDR +: LEN_PREG_ADDR];
      assign d_in   = req_d_rd[gi*LEN_WORD +: LEN_WORD];
      assign ctx_in = req_context[gi*LEN_CONTEXT +: LEN_CONTEXT];

      // Writes to p0 and already-squashed results are accepted but dropped.
      assign push[gi] = req_accepted[gi] && (pa_in != '0) &&
                        !is_killed(branch_hazard, hazard_context, ctx_in);

      assign candidate[gi] = head_valid[gi] &
                             ~is_killed(branch_hazard, hazard_context, get_ctx(head_entry[gi]));
      assign pop_grant[gi] = grant_found && (grant_idx == RR_W'(gi));

      wb_queue #(
        .DEPTH (DEPTH)
      ) u_queue (
        .clk            (clk),
        .rstn           (rstn),
        .push           (push[gi]),
        .push_entry     (entry_pack(pa_in, d_in, ctx_in)),
        .pop_grant      (pop_grant[gi]),
        .branch_hazard  (branch_hazard),
        .hazard_context (hazard_context),
        .full           (full[gi]),
        .head_valid     (head_valid[gi]),
        .head_entry     (head_entry[gi]),
        .entry_live     (entry_live[gi]),
        .entry_pa       (entry_pa[gi])
      );
    end
  endgenerate

  // Cyclic search for the first candidate at or after rr_ptr. The pointer
  // moves past the winner, so every unit with a live head is served within
  // N_REQ cycles.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_found && candidate[idx]) begin
        grant_found = 1'b1;
        grant_idx   = RR_W'(idx);
      end
    end
  end

  // Next state of the write stage and the round-robin pointer.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    stage_valid_d = grant_found;
    stage_entry_d = stage_entry_q;
    if (grant_found) begin
      stage_entry_d = head_entry[grant_idx];
      rr_ptr_d      = (grant_idx == RR_W'(N_REQ-1)) ? '0 : grant_idx + RR_W'(1);
    end
  end

  // Arbiter and write-stage registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q      <= '0;
      stage_valid_q <= 1'b0;
      stage_entry_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      stage_valid_q <= stage_valid_d;
      stage_entry_q <= stage_entry_d;
    end
  end

  // A hazard hitting the staged entry suppresses the write in that same
  // cycle. The stage is then reloaded at the next edge anyway.
  assign stage_live = stage_valid_q &
                      ~is_killed(branch_hazard, hazard_context, get_ctx(stage_entry_q));
  assign w1_order   = stage_live;
  assign w1_pa_rd   = get_pa(stage_entry_q);
  assign w1_d_rd    = get_d(stage_entry_q);

  // One-hot OR of every live destination, queued or staged. p0 is never a
  // real destination, so its bit is held low.
  always_comb begin
    logic [NUM_PREG-1:0] mask;
    mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (entry_live[i][j]) begin
          mask[entry_pa[i][j*LEN_PREG_ADDR +: LEN_PREG_ADDR]] = 1'b1;
        end
      end
    end
    if (stage_live) begin
      mask[get_pa(stage_entry_q)] = 1'b1;
    end
    mask[0]    = 1'b0;
    pending_rd = mask;
  end

endmodule
